// File: rtl/elastic_pipe_pkg.sv
// Shared helpers for the elastic pipeline: count-width sizing and parameter sanity checks.
package elastic_pipe_pkg;

  function automatic int cnt_width(input int n);
    return ($clog2(n + 1) > 1) ? $clog2(n + 1) : 1;
  endfunction

  function automatic bit check_param_pos(input int v);
    return v >= 1;
  endfunction

  function automatic bit check_param_nonneg(input int v);
    return v >= 0;
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One elastic stage: a valid/data register pair that loads on take and empties on adv.
module elastic_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         flush,
  input  logic         take,
  input  logic         adv,
  input  logic [W-1:0] src,
  output logic         vld,
  output logic [W-1:0] dat
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  // Flush only drops the valid bit; payload is left as-is.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (clk_en) begin
      if (take) begin
        vld_d = 1'b1;
        dat_d = src;
      end else if (adv) begin
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld = vld_q;
  assign dat = dat_q;

endmodule

// File: rtl/elastic_pipe.sv
// N-stage valid/ready pipeline with bubble collapsing and occupancy count.
// Optional flush input enabled by defining CX_ELASTIC_PIPE_FLUSH_EN.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter  int W  = 1,
  parameter  int N  = 1,
  localparam int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
`ifdef CX_ELASTIC_PIPE_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  logic flushActive;
`ifdef CX_ELASTIC_PIPE_FLUSH_EN
  assign flushActive = flush;
`else
  assign flushActive = 1'b0;
`endif

  if (!check_param_pos(W) || !check_param_nonneg(N)) begin : g_param_err
    $error("elastic_pipe: W must be >= 1 and N must be >= 0");
  end

  if (N == 0) begin : g_passthru
    logic unused_n0;
    assign unused_n0 = ^{clk, rst};
    assign out_valid = in_valid && clk_en && !flushActive;
    assign in_ready  = out_ready && clk_en && !flushActive;
    assign out_data  = in_data;
    assign count     = '0;
  end else begin : g_pipe
    logic [N-1:0] vld;
    logic [N-1:0] adv;
    logic [W-1:0] chain [N+1];
    logic         inXfer;

    // Ready ripples from the output back to the head, so a stalled tail
    // still lets earlier items slide into empty slots.
    always_comb begin
      adv      = '0;
      adv[N-1] = vld[N-1] && out_ready;
      for (int i = N - 2; i >= 0; i--) begin
        adv[i] = vld[i] && (!vld[i+1] || adv[i+1]);
      end
    end

    assign in_ready  = clk_en && !flushActive && (!vld[0] || adv[0]);
    assign inXfer    = in_valid && in_ready;
    assign chain[0]  = in_data;
    assign out_valid = clk_en && !flushActive && vld[N-1];
    assign out_data  = chain[N];

    for (genvar i = 0; i < N; i++) begin : g_stage
      logic takeI;
      if (i == 0) begin : g_head
        assign takeI = inXfer;
      end else begin : g_body
        assign takeI = adv[i-1];
      end

      elastic_stage #(.W(W)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .flush  (flushActive),
        .take   (takeI),
        .adv    (adv[i]),
        .src    (chain[i]),
        .vld    (vld[i]),
        .dat    (chain[i+1])
      );
    end

    always_comb begin
      count = '0;
      for (int i = 0; i < N; i++) begin
        count = count + CW'(vld[i]);
      end
    end
  end

endmodule
